// File: rtl/positmult_arbiter_es3.sv
// Round-robin front end that shares one fixed-latency posit multiplier between NREQ requesters.
// It carries the requester id through a tag pipe that runs alongside the multiplier and routes each result back to its requester.
module positmult_arbiter_es3 #(
    parameter int NREQ                               = 4,
    parameter int LATENCY                            = 4,
    parameter int POSIT_SERIALIZED_WIDTH_ES3         = 16,
    parameter int POSIT_SERIALIZED_WIDTH_SUM_ES3     = 20,
    parameter int POSIT_SERIALIZED_WIDTH_PRODUCT_ES3 = 24
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic [NREQ-1:0]                               req_valid,
    output logic [NREQ-1:0]                               req_ready,
    input  logic [NREQ*POSIT_SERIALIZED_WIDTH_SUM_ES3-1:0] req_in1,
    input  logic [NREQ*POSIT_SERIALIZED_WIDTH_ES3-1:0]    req_in2,
    input  logic [2*NREQ-1:0]                             req_trunc,
    input  logic                                          issue_en,
    output logic                                          mult_start,
    output logic [POSIT_SERIALIZED_WIDTH_SUM_ES3-1:0]     mult_in1,
    output logic [POSIT_SERIALIZED_WIDTH_ES3-1:0]         mult_in2,
    output logic                                          mult_in1_truncated,
    output logic                                          mult_in2_truncated,
    input  logic [POSIT_SERIALIZED_WIDTH_PRODUCT_ES3-1:0] mult_result,
    input  logic                                          mult_done,
    input  logic                                          mult_truncated,
    output logic [NREQ-1:0]                               rsp_valid,
    output logic [POSIT_SERIALIZED_WIDTH_PRODUCT_ES3-1:0] rsp_result,
    output logic                                          rsp_truncated,
    output logic                                          busy,
    output logic                                          err
);
    localparam int SW  = POSIT_SERIALIZED_WIDTH_SUM_ES3;
    localparam int PW  = POSIT_SERIALIZED_WIDTH_ES3;
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(LATENCY + 1);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           tag_vld_q [LATENCY];
    logic [IDW-1:0] tag_id_q  [LATENCY];
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  guard_q, guard_d;
    logic           err_q, err_d;

    logic           grant_vld;
    logic [IDW-1:0] grant_id;
    logic           xfer;
    logic           done;
    logic           exit_vld;
    logic [IDW-1:0] exit_id;
    logic           hit;
    logic           mismatch;

    // Two passes give round-robin priority: first ptr..NREQ-1, then 0..ptr-1.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_vld && req_valid[i] && (IDW'(i) >= ptr_q)) begin
                grant_vld = 1'b1;
                grant_id  = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_vld && req_valid[i] && (IDW'(i) < ptr_q)) begin
                grant_vld = 1'b1;
                grant_id  = IDW'(i);
            end
        end
    end

    // reset_n gates issue so that nothing leaves the block while reset is held.
    assign xfer       = issue_en & reset_n & grant_vld;
    assign mult_start = xfer;

    always_comb begin
        req_ready          = '0;
        mult_in1           = '0;
        mult_in2           = '0;
        mult_in1_truncated = 1'b0;
        mult_in2_truncated = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (xfer && (grant_id == IDW'(i))) begin
                req_ready[i]       = 1'b1;
                mult_in1           = req_in1[i*SW +: SW];
                mult_in2           = req_in2[i*PW +: PW];
                mult_in1_truncated = req_trunc[2*i];
                mult_in2_truncated = req_trunc[2*i+1];
            end
        end
    end

    // Done is only trusted as a clean 1; X or Z counts as idle.
    assign done     = (mult_done === 1'b1);
    assign exit_vld = tag_vld_q[LATENCY-1];
    assign exit_id  = tag_id_q[LATENCY-1];
    assign hit      = done & exit_vld;
    // While the guard window is open, a done from the unreset multiplier is stale and ignored.
    assign mismatch = (done & ~exit_vld & (guard_q == '0)) | (~done & exit_vld);

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (hit && (exit_id == IDW'(i))) begin
                rsp_valid[i] = 1'b1;
            end
        end
    end

    assign rsp_result    = hit ? mult_result : '0;
    assign rsp_truncated = hit & mult_truncated;
    assign busy          = (cnt_q != '0);
    assign err           = err_q;

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
        cnt_d = cnt_q;
        case ({xfer, exit_vld})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        guard_d = (guard_q != '0) ? guard_q - 1'b1 : guard_q;
        err_d   = err_q | mismatch;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            guard_q <= CW'(LATENCY);
            err_q   <= 1'b0;
            for (int s = 0; s < LATENCY; s++) begin
                tag_vld_q[s] <= 1'b0;
                tag_id_q[s]  <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            guard_q      <= guard_d;
            err_q        <= err_d;
            tag_vld_q[0] <= xfer;
            tag_id_q[0]  <= grant_id;
            for (int s = 1; s < LATENCY; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
        end
    end

endmodule

// File: tb/tb_positmult_arbiter_es3.sv
// Directed bench for positmult_arbiter_es3 with a behavioural fixed-latency multiplier that is never reset.
module tb_positmult_arbiter_es3;
    localparam int NREQ = 4;
    localparam int LAT  = 4;
    localparam int PW   = 16;
    localparam int SW   = 20;
    localparam int RW   = 24;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*SW-1:0]   req_in1;
    logic [NREQ*PW-1:0]   req_in2;
    logic [2*NREQ-1:0]    req_trunc;
    logic                 issue_en;
    logic                 mult_start;
    logic [SW-1:0]        mult_in1;
    logic [PW-1:0]        mult_in2;
    logic                 mult_in1_truncated;
    logic                 mult_in2_truncated;
    logic [RW-1:0]        mult_result;
    logic                 mult_done;
    logic                 mult_truncated;
    logic [NREQ-1:0]      rsp_valid;
    logic [RW-1:0]        rsp_result;
    logic                 rsp_truncated;
    logic                 busy;
    logic                 err;

    logic                 inj_done = 1'b0;
    int                   nchk = 0;
    int                   nerr = 0;

    logic                 mdl_v [LAT] = '{default: 1'b0};
    logic [RW-1:0]        mdl_r [LAT] = '{default: '0};
    logic                 mdl_t [LAT] = '{default: 1'b0};

    always #5 clk = ~clk;

    positmult_arbiter_es3 #(
        .NREQ(NREQ), .LATENCY(LAT),
        .POSIT_SERIALIZED_WIDTH_ES3(PW),
        .POSIT_SERIALIZED_WIDTH_SUM_ES3(SW),
        .POSIT_SERIALIZED_WIDTH_PRODUCT_ES3(RW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2), .req_trunc(req_trunc),
        .issue_en(issue_en),
        .mult_start(mult_start), .mult_in1(mult_in1), .mult_in2(mult_in2),
        .mult_in1_truncated(mult_in1_truncated), .mult_in2_truncated(mult_in2_truncated),
        .mult_result(mult_result), .mult_done(mult_done), .mult_truncated(mult_truncated),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_truncated(rsp_truncated),
        .busy(busy), .err(err)
    );

    function automatic logic [RW-1:0] mfun(input logic [SW-1:0] a, input logic [PW-1:0] b);
        return {a[11:0], b[11:0]};
    endfunction

    function automatic logic [SW-1:0] op1(input int i);
        return SW'(32'h000A_3000 + i * 32'h111);
    endfunction

    function automatic logic [PW-1:0] op2(input int i);
        return PW'(32'h0000_5C00 + i * 32'h23);
    endfunction

    // Stand-in multiplier: fixed latency, no reset, so stale results survive a reset.
    always @(posedge clk) begin
        mdl_v[0] <= mult_start;
        mdl_r[0] <= mfun(mult_in1, mult_in2);
        mdl_t[0] <= mult_in1_truncated | mult_in2_truncated;
        for (int i = 1; i < LAT; i++) begin
            mdl_v[i] <= mdl_v[i-1];
            mdl_r[i] <= mdl_r[i-1];
            mdl_t[i] <= mdl_t[i-1];
        end
    end

    assign mult_done      = mdl_v[LAT-1] | inj_done;
    assign mult_result    = mdl_r[LAT-1];
    assign mult_truncated = mdl_t[LAT-1];

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) next();
    endtask

    task automatic do_reset();
        req_valid = '0;
        reset_n   = 1'b0;
        next();
        next();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        issue_en  = 1'b1;
        req_valid = '1;
        next();
        next();
        @(negedge clk);
        nchk++; if (req_ready !== 4'b0000) begin nerr++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        nchk++; if (mult_start !== 1'b0) begin nerr++; $display("FAIL reset_start: got %b want 0", mult_start); end
        nchk++; if (rsp_valid !== 4'b0000) begin nerr++; $display("FAIL reset_rsp: got %b want 0000", rsp_valid); end
        nchk++; if (busy !== 1'b0 || err !== 1'b0) begin nerr++; $display("FAIL reset_busy_err: got busy=%b err=%b want 0/0", busy, err); end
        next();
        req_valid = '0;
        reset_n   = 1'b1;
        idle(LAT + 1);
    endtask

    task automatic test_single();
        logic [NREQ-1:0] e_rsp;
        req_valid = 4'b0100;
        @(negedge clk);
        nchk++; if (req_ready !== 4'b0100) begin nerr++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        nchk++; if (mult_start !== 1'b1) begin nerr++; $display("FAIL single_start: got %b want 1", mult_start); end
        nchk++; if (mult_in1 !== op1(2) || mult_in2 !== op2(2)) begin nerr++; $display("FAIL single_operands: got %h/%h want %h/%h", mult_in1, mult_in2, op1(2), op2(2)); end
        nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL single_busy_pre: got %b want 0", busy); end
        next();
        req_valid = '0;
        for (int c = 1; c <= LAT; c++) begin
            e_rsp = (c == LAT) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            nchk++; if (busy !== 1'b1) begin nerr++; $display("FAIL single_busy c%0d: got %b want 1", c, busy); end
            nchk++; if (rsp_valid !== e_rsp) begin nerr++; $display("FAIL single_rsp c%0d: got %b want %b", c, rsp_valid, e_rsp); end
            nchk++; if (mult_start !== 1'b0 || mult_in1 !== '0) begin nerr++; $display("FAIL single_idle_bus c%0d: got start=%b in1=%h want 0/0", c, mult_start, mult_in1); end
            if (c == LAT) begin
                nchk++; if (rsp_result !== mfun(op1(2), op2(2))) begin nerr++; $display("FAIL single_result: got %h want %h", rsp_result, mfun(op1(2), op2(2))); end
            end
            next();
        end
        @(negedge clk);
        nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL single_busy_post: got %b want 0", busy); end
        next();
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] e_rdy;
        logic [NREQ-1:0] e_rsp;
        int r;
        do_reset();
        idle(LAT + 1);
        req_valid = '1;
        for (int c = 0; c < 12; c++) begin
            if (c == 8) req_valid = '0;
            e_rdy = '0;
            if (c < 8) e_rdy[c % NREQ] = 1'b1;
            e_rsp = '0;
            r = (c - LAT) % NREQ;
            if (c >= LAT) e_rsp[r] = 1'b1;
            @(negedge clk);
            nchk++; if (req_ready !== e_rdy) begin nerr++; $display("FAIL rr_ready c%0d: got %b want %b", c, req_ready, e_rdy); end
            if (c < 8) begin
                nchk++; if (mult_in1 !== op1(c % NREQ)) begin nerr++; $display("FAIL rr_in1 c%0d: got %h want %h", c, mult_in1, op1(c % NREQ)); end
            end
            nchk++; if (rsp_valid !== e_rsp) begin nerr++; $display("FAIL rr_rsp c%0d: got %b want %b", c, rsp_valid, e_rsp); end
            if (c >= LAT) begin
                nchk++; if (rsp_result !== mfun(op1(r), op2(r))) begin nerr++; $display("FAIL rr_result c%0d: got %h want %h", c, rsp_result, mfun(op1(r), op2(r))); end
            end
            next();
        end
    endtask

    task automatic test_issue_en();
        req_valid = '1;
        issue_en  = 1'b1;
        @(negedge clk);
        nchk++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL ie_ready c0: got %b want 0001", req_ready); end
        next();
        @(negedge clk);
        nchk++; if (req_ready !== 4'b0010) begin nerr++; $display("FAIL ie_ready c1: got %b want 0010", req_ready); end
        next();
        issue_en = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            nchk++; if (req_ready !== 4'b0000 || mult_start !== 1'b0) begin nerr++; $display("FAIL ie_hold c%0d: got ready=%b start=%b want 0000/0", c, req_ready, mult_start); end
            nchk++;
            if (rsp_valid !== ((c == 4) ? 4'b0001 : (c == 5) ? 4'b0010 : 4'b0000)) begin
                nerr++; $display("FAIL ie_rsp c%0d: got %b", c, rsp_valid);
            end
            nchk++; if (busy !== (c < 6)) begin nerr++; $display("FAIL ie_busy c%0d: got %b want %b", c, busy, (c < 6)); end
            next();
        end
        issue_en = 1'b1;
        @(negedge clk);
        nchk++; if (req_ready !== 4'b0100) begin nerr++; $display("FAIL ie_ptr_hold: got %b want 0100", req_ready); end
        next();
        req_valid = '0;
        idle(LAT + 1);
    endtask

    task automatic test_trunc();
        req_trunc = 8'b0000_0100;
        req_valid = 4'b0010;
        @(negedge clk);
        nchk++; if (req_ready !== 4'b0010) begin nerr++; $display("FAIL tr_ready: got %b want 0010", req_ready); end
        nchk++; if (mult_in1_truncated !== 1'b1 || mult_in2_truncated !== 1'b0) begin nerr++; $display("FAIL tr_flags: got %b/%b want 1/0", mult_in1_truncated, mult_in2_truncated); end
        next();
        req_valid = '0;
        req_trunc = '0;
        idle(LAT - 1);
        @(negedge clk);
        nchk++; if (rsp_valid !== 4'b0010 || rsp_truncated !== 1'b1) begin nerr++; $display("FAIL tr_rsp: got %b/%b want 0010/1", rsp_valid, rsp_truncated); end
        nchk++; if (rsp_result !== mfun(op1(1), op2(1))) begin nerr++; $display("FAIL tr_result: got %h want %h", rsp_result, mfun(op1(1), op2(1))); end
        next();
        idle(2);
    endtask

    task automatic test_err();
        @(negedge clk);
        nchk++; if (err !== 1'b0) begin nerr++; $display("FAIL err_pre: got %b want 0", err); end
        next();
        inj_done = 1'b1;
        @(negedge clk);
        nchk++; if (rsp_valid !== 4'b0000) begin nerr++; $display("FAIL err_rsp: got %b want 0000", rsp_valid); end
        next();
        inj_done = 1'b0;
        @(negedge clk);
        nchk++; if (err !== 1'b1) begin nerr++; $display("FAIL err_set: got %b want 1", err); end
        next();
        idle(3);
        @(negedge clk);
        nchk++; if (err !== 1'b1 || rsp_valid !== 4'b0000) begin nerr++; $display("FAIL err_sticky: got err=%b rsp=%b want 1/0000", err, rsp_valid); end
        next();
    endtask

    task automatic test_reset_inflight();
        do_reset();
        @(negedge clk);
        nchk++; if (err !== 1'b0) begin nerr++; $display("FAIL rif_err_clear: got %b want 0", err); end
        next();
        idle(LAT + 1);
        req_valid = 4'b0111;
        idle(3);
        req_valid = '0;
        reset_n   = 1'b0;
        @(negedge clk);
        nchk++; if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin nerr++; $display("FAIL rif_during: got busy=%b rsp=%b want 0/0000", busy, rsp_valid); end
        next();
        reset_n = 1'b1;
        for (int c = 0; c < LAT + 2; c++) begin
            @(negedge clk);
            nchk++; if (rsp_valid !== 4'b0000 || err !== 1'b0) begin nerr++; $display("FAIL rif_after c%0d: got rsp=%b err=%b want 0000/0", c, rsp_valid, err); end
            next();
        end
        @(negedge clk);
        nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL rif_busy: got %b want 0", busy); end
    endtask

    initial begin
        req_valid = '0;
        req_trunc = '0;
        issue_en  = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_in1[i*SW +: SW] = op1(i);
            req_in2[i*PW +: PW] = op2(i);
        end
        test_reset();
        test_single();
        test_round_robin();
        test_issue_en();
        test_trunc();
        test_err();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/positmult_arbiter_es3.md
POSITMULT_ARBITER_ES3 -- requirements
Module: positmult_arbiter_es3

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing one multiplier (2..8).
REQ-002 Parameter LATENCY, default 4, SHALL set the start-to-done latency of the shared multiplier in cycles.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  input  NREQ  SHALL flag that requester i presents an operand pair.
REQ-006 req_ready  output  NREQ  SHALL flag acceptance of requester i's operands this cycle.
REQ-007 req_in1  input  NREQ*POSIT_SERIALIZED_WIDTH_SUM_ES3  SHALL carry the sum-format operand, slice i for requester i.
REQ-008 req_in2  input  NREQ*POSIT_SERIALIZED_WIDTH_ES3  SHALL carry the posit operand, slice i.
REQ-009 req_trunc  input  2*NREQ  SHALL carry {in2_truncated, in1_truncated}, slice i.
REQ-010 issue_en  input  1  SHALL permit new grants when high; low stops issue and lets in-flight operations drain.
REQ-011 mult_start, mult_in1, mult_in2, mult_in1_truncated, mult_in2_truncated  output  1/SUM/POSIT/1/1  SHALL drive the shared multiplier.
REQ-012 mult_result, mult_done, mult_truncated  input  POSIT_SERIALIZED_WIDTH_PRODUCT_ES3/1/1  SHALL be the multiplier outputs.
REQ-013 rsp_valid  output  NREQ  SHALL pulse for one cycle when requester i's result is present.
REQ-014 rsp_result, rsp_truncated  output  PRODUCT/1  SHALL be shared result buses, valid only while a rsp_valid bit is high.
REQ-015 busy  output  1  SHALL be high while any operation is in flight.
REQ-016 err  output  1  SHALL be a sticky flag for a done/tag mismatch.

Function
REQ-017 Grant: at most one requester per cycle, round-robin starting at the index after the last granted one; pointer resets to 0.
REQ-018 req_ready[i] SHALL be combinational: high iff issue_en is high, req_valid[i] is high and i wins arbitration; transfer occurs when valid and ready are both high.
REQ-019 Issue: on a transfer, mult_start=1 in that same cycle and the mult_* operand ports SHALL carry slice i; otherwise mult_start=0 and the operand ports SHALL be all zero.
REQ-020 Throughput: one issue per cycle, no bubbles; requester i holding valid with k other active requesters SHALL be granted within k+1 cycles.
REQ-021 Tag pipe: LATENCY-stage shift register of {valid, id}; stage 0 loads {transfer, granted id}.
REQ-022 Return: when mult_done=1 and the tag leaving the pipe in that cycle is valid, rsp_valid[id]=1 and rsp_result/rsp_truncated SHALL equal mult_result/mult_truncated in that cycle; the path is combinational, with no added latency and no backpressure.
REQ-023 Total latency: transfer in cycle t SHALL yield rsp_valid in cycle t+LATENCY.
REQ-024 Outstanding counter, range 0..LATENCY: increment on transfer, decrement on tag exit, no change on simultaneous events; busy = (count != 0).
REQ-025 Mismatch: mult_done=1 with an invalid exiting tag, or mult_done=0 with a valid exiting tag, SHALL set err; err clears only on reset, and no rsp_valid SHALL be raised on a mismatch.
REQ-026 An X on mult_done SHALL be treated as 0.
REQ-027 issue_en low SHALL NOT disturb in-flight tags; the round-robin pointer SHALL hold.

Reset
REQ-028 Asserting reset_n low SHALL immediately clear the tag pipe, counter, pointer, err, mult_start, req_ready, rsp_valid and busy to 0.
REQ-029 The multiplier is unreset, so for LATENCY cycles after reset release any mult_done SHALL be discarded without setting err.
REQ-030 Reset asserted mid-operation SHALL drop all in-flight results, and they SHALL NOT be delivered.

Verification
REQ-031 Single request: req_valid[2]=1 at cycle 10 with pointer 0 -> req_ready[2]=1 and mult_start=1 at cycle 10; rsp_valid=4'b0100 at cycle 14; busy high during cycles 11-14.
REQ-032 All four requesters valid continuously from cycle 0 -> grants 0,1,2,3,0,... each cycle; rsp_valid one-hot in the same order from cycle 4.
REQ-033 issue_en dropped at cycle 2 during back-to-back traffic -> no grants from cycle 2; the two in-flight results return in cycles 4-5; busy low from cycle 6.
REQ-034 Bench injects an extra mult_done pulse with an empty pipe -> err=1 and stays 1; rsp_valid stays 0.
REQ-035 reset_n pulsed low with 3 operations in flight -> no rsp_valid afterward; the stale mult_done pulses within LATENCY cycles of release leave err at 0.
REQ-036 Operands with in1_truncated=1 -> mult_in1_truncated=1 at issue; bench multiplier returns truncated=1 -> rsp_truncated=1 with rsp_valid.
